// File: rtl/lsu_align.sv
// Load/store alignment unit: word address, byte lanes, lane-rotated store data and load realignment.
// Optional LSU_MISALIGN_SPLIT_EN: word-crossing accesses are split into two memory accesses.
module lsu_align #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            mem_we,
  output logic [3:0]      mem_byteEnable,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [1:0]      dbg_state_o
);

  // Request handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, and req_* are ignored in every other state.
  typedef enum logic [1:0] {IDLE = 2'd0, ACC0 = 2'd1, ACC1 = 2'd2, RESP = 2'd3} state_t;

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SplitEn = 1'b1;
`else
  localparam bit SplitEn = 1'b0;
`endif

  state_t          state_q, state_d;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] addr_q, wdata_q, w0_q;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [7:0]      lane_span;
  logic            crossing;
  logic [XLEN-1:0] wdata_rot;
  logic            req_bad;

  function automatic logic [3:0] size_mask(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic illegal_f3(input logic we, input logic [2:0] f3);
    if (we) illegal_f3 = !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010);
    else    illegal_f3 = (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
  endfunction

  function automatic logic not_natural(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   not_natural = off[0];
      2'b10:   not_natural = (off != 2'b00);
      default: not_natural = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] rotl8(input logic [31:0] w, input logic [1:0] off);
    case (off)
      2'd0:    rotl8 = w;
      2'd1:    rotl8 = {w[23:0], w[31:24]};
      2'd2:    rotl8 = {w[15:0], w[31:16]};
      default: rotl8 = {w[7:0], w[31:8]};
    endcase
  endfunction

  // Lanes at or above the offset come from the first word, lower lanes from the second.
  function automatic logic [31:0] load_result(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] w0, input logic [31:0] w1);
    logic [31:0] merged;
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      merged[8*i +: 8] = (i >= int'(off)) ? w0[8*i +: 8] : w1[8*i +: 8];
    case (off)
      2'd0:    r = merged;
      2'd1:    r = {merged[7:0], merged[31:8]};
      2'd2:    r = {merged[15:0], merged[31:16]};
      default: r = {merged[23:0], merged[31:24]};
    endcase
    case (f3)
      3'b000:  load_result = {{24{r[7]}}, r[7:0]};
      3'b001:  load_result = {{16{r[15]}}, r[15:0]};
      3'b100:  load_result = {24'd0, r[7:0]};
      3'b101:  load_result = {16'd0, r[15:0]};
      default: load_result = r;
    endcase
  endfunction

  assign lane_span   = {4'b0000, size_mask(f3_q)} << addr_q[1:0];
  assign crossing    = SplitEn && (lane_span[7:4] != 4'b0000);
  assign wdata_rot   = rotl8(wdata_q, addr_q[1:0]);
  assign req_bad     = illegal_f3(req_we, req_funct3) ||
                       (!SplitEn && not_natural(req_funct3, req_addr[1:0]));
  assign req_ready   = (state_q == IDLE);
  assign resp_valid  = (state_q == RESP);
  assign resp_rdata  = rdata_q;
  assign resp_err    = err_q;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d        = state_q;
    rdata_d        = rdata_q;
    err_d          = err_q;
    mem_we         = 1'b0;
    mem_byteEnable = 4'b0000;
    mem_addr       = '0;
    mem_wdata      = '0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_bad) begin
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = ACC0;
          end
        end
      end
      ACC0: begin
        mem_addr       = {addr_q[31:2], 2'b00};
        mem_byteEnable = lane_span[3:0];
        mem_wdata      = wdata_rot;
        mem_we         = we_q;
        if (crossing) begin
          state_d = ACC1;
        end else begin
          state_d = RESP;
          err_d   = 1'b0;
          rdata_d = we_q ? '0 : load_result(f3_q, addr_q[1:0], mem_rdata, mem_rdata);
        end
      end
      ACC1: begin
        mem_addr       = {addr_q[31:2], 2'b00} + 32'd4;
        mem_byteEnable = lane_span[7:4];
        mem_wdata      = wdata_rot;
        mem_we         = we_q;
        state_d        = RESP;
        err_d          = 1'b0;
        rdata_d        = we_q ? '0 : load_result(f3_q, addr_q[1:0], w0_q, mem_rdata);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      w0_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (state_q == IDLE && req_valid) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state_q == ACC0) w0_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_lsu_align.sv
// Bench for lsu_align: table vectors, reset-abort sequence and random traffic against a byte-level model.
module tb_lsu_align;

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_we;
  logic [3:0]  mem_byteEnable;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  dbg_state;

  lsu_align #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_we(mem_we), .mem_byteEnable(mem_byteEnable), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state_o(dbg_state)
  );

  // ---------------- memory (16 words, aliased on addr[5:2]) ----------------
  logic [31:0] mem [16];
  logic [31:0] mem_exp [16];
  assign mem_rdata = mem[mem_addr[5:2]];

  always @(posedge clk)
    if (mem_we)
      for (int l = 0; l < 4; l++)
        if (mem_byteEnable[l]) mem[mem_addr[5:2]][8*l +: 8] <= mem_wdata[8*l +: 8];

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- reference model (byte-granular) ----------------
  logic        m_err;
  logic [31:0] m_rdata;
  int          m_lat, m_nacc;
  logic [31:0] m_addr [2];
  logic [3:0]  m_be [2];
  logic [31:0] m_wd [2];

  task automatic model_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata);
    int size;
    logic legal, misal;
    logic [31:0] ba, val;
    int j;
    size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    legal = we ? (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010)
               : !(f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    misal = (addr % size) != 0;
    m_err = !legal || (!SPLIT && misal);
    m_rdata = 32'd0;
    m_nacc = 0;
    m_be[0] = 4'd0; m_be[1] = 4'd0; m_wd[0] = 32'd0; m_wd[1] = 32'd0;
    m_addr[0] = addr & 32'hFFFF_FFFC;
    m_addr[1] = m_addr[0] + 32'd4;
    if (m_err) begin
      m_lat = 1;
    end else begin
      val = 32'd0;
      for (int k = 0; k < size; k++) begin
        ba = addr + k;
        j = ((ba & 32'hFFFF_FFFC) == m_addr[0]) ? 0 : 1;
        m_be[j][ba[1:0]] = 1'b1;
        if (we) begin
          m_wd[j][8*ba[1:0] +: 8] = wdata[8*k +: 8];
          mem_exp[ba[5:2]][8*ba[1:0] +: 8] = wdata[8*k +: 8];
        end else begin
          val[8*k +: 8] = mem_exp[ba[5:2]][8*ba[1:0] +: 8];
        end
      end
      m_nacc = (m_be[1] != 4'd0) ? 2 : 1;
      m_lat  = 1 + m_nacc;
      if (!we) begin
        case (f3)
          3'b000:  m_rdata = {{24{val[7]}}, val[7:0]};
          3'b001:  m_rdata = {{16{val[15]}}, val[15:0]};
          default: m_rdata = val;
        endcase
      end
    end
  endtask

  // ---------------- driver ----------------
  int          g_lat, g_nacc;
  logic        g_err;
  logic [31:0] g_rdata;
  logic [31:0] g_addr [2];
  logic [3:0]  g_be [2];
  logic [31:0] g_wd [2];
  logic        g_we [2];

  task automatic preload(input logic [31:0] addr, input logic [31:0] w0, input logic [31:0] w1);
    logic [31:0] a1;
    a1 = addr + 32'd4;
    @(negedge clk);
    mem[addr[5:2]] <= w0;
    mem[a1[5:2]]   <= w1;
    mem_exp[addr[5:2]] = w0;
    mem_exp[a1[5:2]]   = w1;
  endtask

  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
    logic [31:0] exp_r, mask;
    logic seen, mem_ok;
    model_txn(we, f3, addr, wdata);
    exp_q.push_back(m_rdata);
    @(negedge clk);
    check32("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    // Inputs scrambled while busy: the unit must ignore them.
    req_valid = 1'($urandom_range(0, 1)); req_we = 1'($urandom_range(0, 1));
    req_funct3 = 3'($urandom_range(0, 7)); req_addr = $urandom; req_wdata = $urandom;
    seen = 1'b0; g_lat = 0; g_nacc = 0; g_err = 1'b0; g_rdata = 32'd0;
    g_be[0] = 4'd0; g_addr[0] = 32'd0; g_wd[0] = 32'd0;
    for (int c = 1; c <= 8 && !seen; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        seen = 1'b1; g_lat = c; g_err = resp_err; g_rdata = resp_rdata;
        check32("resp_no_mem", {27'd0, mem_we, mem_byteEnable}, 32'd0);
      end else if (mem_byteEnable != 4'd0 || mem_we) begin
        if (g_nacc < 2) begin
          g_addr[g_nacc] = mem_addr; g_be[g_nacc] = mem_byteEnable;
          g_wd[g_nacc] = mem_wdata; g_we[g_nacc] = mem_we;
        end
        g_nacc++;
      end
    end
    req_valid = 1'b0;
    exp_r = exp_q.pop_front();
    if (!seen) begin
      n_checks++; n_errors++;
      $display("FAIL resp_timeout: no resp_valid within 8 cycles for addr %h", addr);
    end else begin
      check32("latency", g_lat, m_lat);
      check32("resp_err", {31'd0, g_err}, {31'd0, m_err});
      check32("resp_rdata", g_rdata, exp_r);
    end
    check32("access_count", g_nacc, m_nacc);
    for (int j = 0; j < 2; j++) begin
      if (j < m_nacc && j < g_nacc) begin
        check32("acc_addr", g_addr[j], m_addr[j]);
        check32("acc_be_we", {27'd0, g_we[j], g_be[j]}, {27'd0, we, m_be[j]});
        if (we) begin
          for (int l = 0; l < 4; l++) mask[8*l +: 8] = {8{m_be[j][l]}};
          check32("acc_wdata", g_wd[j] & mask, m_wd[j]);
        end
      end
    end
    @(negedge clk);
    check32("resp_pulse_hold", {resp_valid, req_ready, 30'd0} ^ resp_rdata, {1'b0, 1'b1, 30'd0} ^ exp_r);
    mem_ok = 1'b1;
    for (int i = 0; i < 16; i++) if (mem[i] !== mem_exp[i]) mem_ok = 1'b0;
    check32("memory_image", {31'd0, mem_ok}, 32'd1);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pre_w0;
    logic [31:0] pre_w1;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    logic [3:0]  exp_be0;
    logic [31:0] exp_maddr0;
    logic [31:0] exp_mwdata0;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic [31:0] r;
    logic drop_ok, no_resp;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'd0; req_wdata = 32'd0;
    rst_n = 1'b0;
    for (int i = 0; i < 16; i++) begin
      r = $urandom;
      mem[i] <= r;
      mem_exp[i] = r;
    end

    vecs[0]  = '{1'b1, 3'b010, 32'h8, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 1'b0, 2, 4'b1111, 32'h8, 32'hDEADBEEF};
    vecs[1]  = '{1'b1, 3'b000, 32'h6, 32'h000000A5, 32'h0, 32'h0, 32'h0, 1'b0, 2, 4'b0100, 32'h4, 32'h00A50000};
    vecs[2]  = '{1'b0, 3'b000, 32'h6, 32'h0, 32'h00A50000, 32'h0, 32'hFFFFFFA5, 1'b0, 2, 4'b0100, 32'h4, 32'h0};
    vecs[3]  = '{1'b0, 3'b100, 32'h6, 32'h0, 32'h00A50000, 32'h0, 32'h000000A5, 1'b0, 2, 4'b0100, 32'h4, 32'h0};
    vecs[4]  = '{1'b0, 3'b011, 32'h8, 32'h0, 32'h12345678, 32'h0, 32'h0, 1'b1, 1, 4'b0000, 32'h0, 32'h0};
    vecs[5]  = '{1'b1, 3'b100, 32'hC, 32'h1, 32'h0, 32'h0, 32'h0, 1'b1, 1, 4'b0000, 32'h0, 32'h0};
    vecs[6]  = '{1'b0, 3'b101, 32'h2, 32'h0, 32'h80017F7F, 32'h0, 32'h00008001, 1'b0, 2, 4'b1100, 32'h0, 32'h0};
    vecs[7]  = '{1'b0, 3'b001, 32'h2, 32'h0, 32'h80017F7F, 32'h0, 32'hFFFF8001, 1'b0, 2, 4'b1100, 32'h0, 32'h0};
    vecs[8]  = '{1'b0, 3'b010, 32'h10, 32'h0, 32'hCAFEF00D, 32'h0, 32'hCAFEF00D, 1'b0, 2, 4'b1111, 32'h10, 32'h0};
    if (SPLIT) begin
      vecs[9]  = '{1'b0, 3'b001, 32'h5, 32'h0, 32'h00807F00, 32'h0, 32'hFFFF807F, 1'b0, 2, 4'b0110, 32'h4, 32'h0};
      vecs[10] = '{1'b0, 3'b010, 32'h3, 32'h0, 32'h11223344, 32'h55667788, 32'h66778811, 1'b0, 3, 4'b1000, 32'h0, 32'h0};
      vecs[11] = '{1'b1, 3'b010, 32'hFFFFFFFE, 32'h12345678, 32'h0, 32'h0, 32'h0, 1'b0, 3, 4'b1100, 32'hFFFFFFFC, 32'h56781234};
    end else begin
      vecs[9]  = '{1'b0, 3'b001, 32'h5, 32'h0, 32'h00807F00, 32'h0, 32'h0, 1'b1, 1, 4'b0000, 32'h0, 32'h0};
      vecs[10] = '{1'b0, 3'b010, 32'h3, 32'h0, 32'h11223344, 32'h55667788, 32'h0, 1'b1, 1, 4'b0000, 32'h0, 32'h0};
      vecs[11] = '{1'b1, 3'b010, 32'hFFFFFFFE, 32'h12345678, 32'h0, 32'h0, 32'h0, 1'b1, 1, 4'b0000, 32'h0, 32'h0};
    end

    // Reset state
    repeat (2) @(negedge clk);
    check32("rst_resp", {resp_valid, resp_err, 30'd0} | resp_rdata, 32'd0);
    check32("rst_mem_ctl", {27'd0, mem_we, mem_byteEnable}, 32'd0);
    check32("rst_mem_addr", mem_addr, 32'd0);
    check32("rst_mem_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check32("ready_after_reset", {31'd0, req_ready}, 32'd1);

    // Table-driven vectors
    for (int v = 0; v < 12; v++) begin
      if (vecs[v].we == 1'b0 || vecs[v].exp_err) preload(vecs[v].addr, vecs[v].pre_w0, vecs[v].pre_w1);
      run_txn(vecs[v].we, vecs[v].f3, vecs[v].addr, vecs[v].wdata);
      check32($sformatf("vec%0d_rdata", v), g_rdata, vecs[v].exp_rdata);
      check32($sformatf("vec%0d_err_lat", v), {g_err, 31'(g_lat)}, {vecs[v].exp_err, 31'(vecs[v].exp_lat)});
      check32($sformatf("vec%0d_be0", v), {28'd0, g_be[0]}, {28'd0, vecs[v].exp_be0});
      if (vecs[v].exp_be0 != 4'd0) check32($sformatf("vec%0d_maddr0", v), g_addr[0], vecs[v].exp_maddr0);
      if (vecs[v].we && !vecs[v].exp_err) check32($sformatf("vec%0d_mwdata0", v), g_wd[0], vecs[v].exp_mwdata0);
    end
    if (SPLIT) check32("wrap_second_access", {g_addr[1][31:4], g_be[1]}, {28'd0, 4'b0011});

    // Reset in the middle of an access
    preload(32'h0, 32'h11111111, 32'h22222222);
    preload(32'h8, 32'h33333333, 32'h44444444);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_wdata = 32'hAABBCCDD;
    req_addr = SPLIT ? 32'h2 : 32'h8;
    @(posedge clk);
    #1 req_valid = 1'b0;
    if (SPLIT) @(posedge clk);
    #1;
    check32("abort_pre_be", {27'd0, mem_we, mem_byteEnable}, {27'd0, 1'b1, (SPLIT ? 4'b0011 : 4'b1111)});
    rst_n = 1'b0;
    #1;
    drop_ok = !mem_we && mem_byteEnable == 4'd0 && !resp_valid && mem_addr == 32'd0 && mem_wdata == 32'd0;
    check32("abort_outputs_drop", {31'd0, drop_ok}, 32'd1);
    no_resp = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (resp_valid) no_resp = 1'b0;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) no_resp = 1'b0;
    end
    check32("abort_no_resp", {31'd0, no_resp}, 32'd1);
    check32("abort_ready", {31'd0, req_ready}, 32'd1);
    if (SPLIT) begin
      mem_exp[0] = 32'hCCDD1111;
      check32("abort_word0", mem[0], 32'hCCDD1111);
      check32("abort_word1", mem[1], 32'h22222222);
    end else begin
      check32("abort_word2", mem[2], 32'h33333333);
    end

    // Random traffic
    for (int t = 0; t < 200; t++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 9) == 0) ? (32'hFFFFFFFC + 32'($urandom_range(0, 3)))
                                      : 32'($urandom_range(0, 63));
      run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lsu_align.md
Name: lsu_align

Overview:
- Load/store alignment unit between the execute stage and the data memory.
- Accepts one load/store request at a time and generates the word-aligned address, 4-bit byte-enable mask and lane-rotated write data for the memory.
- Captures the memory read word, realigns it and sign- or zero-extends it.
- Optionally splits accesses that cross a word boundary into two sequential memory accesses.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle pulse, response complete
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  valid with resp_valid; illegal funct3 or unsupported misalignment
- mem_we  out  1  memory write enable
- mem_byteEnable  out  4  byte lane mask
- mem_addr  out  32  word address; bits [1:0] always 00
- mem_wdata  out  32  lane-rotated write data
- mem_rdata  in  32  combinational read word for mem_addr

Behaviour:
- States: IDLE, ACC0, ACC1, RESP. Reset → IDLE.
- Reset values:
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - mem_we=0, mem_byteEnable=0, mem_addr=0, mem_wdata=0.
  - req_ready=1 once reset has been released.
- IDLE:
  - req_ready=1.
  - On req_valid, latch we, funct3, addr, wdata and set off=addr[1:0], size=1/2/4.
  - Go to ACC0, or directly to RESP with err=1 if funct3 is illegal (loads 011/110/111; stores anything other than 000/001/010).
- ACC0:
  - mem_addr={addr[31:2],2'b00}.
  - mem_byteEnable = lanes off..min(off+size-1,3).
  - mem_wdata = wdata rotated left by 8*off.
  - mem_we = we.
  - Capture mem_rdata into w0 at the clock edge.
  - Go to ACC1 if off+size>4 (crossing), else RESP.
- ACC1:
  - mem_addr = word address + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
  - mem_byteEnable = lanes 0..(off+size-5); same rotated wdata; mem_we=we.
  - Capture w1. Go to RESP.
- RESP:
  - resp_valid=1 for exactly one cycle; resp_rdata and resp_err registered and held until the next response.
  - Next state IDLE. req_ready=0, so back-to-back throughput is one request per 3 cycles (aligned).
- Load assembly:
  - merged lane i = w0 lane i if i>=off, else w1 lane i.
  - Rotate merged right by 8*off, then extend: B sign bit7, H sign bit15, BU/HU zero-extend, W unchanged.
- Latency from accept edge to resp_valid: aligned/non-crossing 2 cycles; crossing 3 cycles.
- Non-crossing misaligned accesses (halfword at off=1) complete in a single access using lanes 1–2.
- Outside ACC0/ACC1: mem_we=0 and mem_byteEnable=0; mem_addr and mem_wdata are don't-care but driven to 0.
- Error responses never assert mem_we or mem_byteEnable.
- Inputs are ignored outside IDLE; changes on req_* after accept have no effect.
- Reset mid-operation: all outputs drop to their reset values immediately.
  - A split store interrupted in ACC1 leaves its first word written and its second word not written.
  - No response is produced for the aborted request.

Optional Feature:
- LSU_MISALIGN_SPLIT_EN.
- Defined: crossing accesses use ACC1 as described above.
- Undefined:
  - Any access not naturally aligned (H with addr[0]=1, W with addr[1:0]≠0) goes IDLE→RESP with resp_err=1 and resp_rdata=0, with no memory access.
  - Naturally aligned accesses behave identically to the defined case.
  - ACC1 is unreachable.

Test Plan:
- SW addr 0x8, wdata 0xDEADBEEF → ACC0: mem_addr 0x8, be 1111, wdata 0xDEADBEEF, we=1; resp_valid 2 cycles after accept, err=0.
- SB addr 0x6, wdata 0x000000A5 → be 0100, mem_wdata 0x00A50000; then LB addr 0x6 with word 0x00A50000 → rdata 0xFFFFFFA5; LBU → 0x000000A5.
- LH addr 0x5, memory word 0x00807F00 → be 0110, rdata 0xFFFF807F, single access, latency 2.
- With LSU_MISALIGN_SPLIT_EN: LW addr 0x3, word@0x0 = 0x11223344, word@0x4 = 0x55667788 → be 1000 then 0111, rdata 0x66778811, resp 3 cycles after accept. Without the macro: err=1, rdata 0, no be asserted.
- Illegal load funct3 011 → resp_err=1 one cycle after accept, mem_byteEnable never nonzero. SW addr 0xFFFFFFFE with the split feature enabled → second access at mem_addr 0x00000000, be 0011.
- Split SW addr 0x2: assert rst_n=0 during ACC1 → mem_we drops in the same cycle, no resp_valid, only lanes 2–3 of word 0x0 modified; req_ready=1 after release.
